// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD-to-binary converter.
package bcd_pkg;
  localparam int BCD_DIGITS    = 4;
  localparam int ACC_W         = 14;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int CNT_W         = 2;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;
endpackage

// File: rtl/bcd_mac_step.sv
// One Horner step of the conversion: acc_o = acc_i * 10 + digit_i, shift-add only.
module bcd_mac_step
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [ACC_W-1:0] acc_o
);
  assign acc_o = (acc_i << 3) + (acc_i << 1) + {{(ACC_W-4){1'b0}}, digit_i};
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter, one digit per clock, saturating to N bits.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   mil,
  input  logic [3:0]   cen,
  input  logic [3:0]   dec,
  input  logic [3:0]   uni,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] bin_out,
  output logic         ovf,
  output logic         err
);

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [ACC_W-1:0]           acc, acc_step;
  logic [4*BCD_DIGITS-1:0]    dig_sr;
  logic                       accept, last;
  logic [N:0]                 sat_res;

  // Returns {ovf, value}: clamp to 2^N-1 when the accumulator does not fit.
  function automatic logic [N:0] saturate(input logic [ACC_W-1:0] a);
    logic [N:0] r;
    r = {1'b0, N'(a)};
    if (N < ACC_W) begin
      if ((a >> N) != '0) r = {1'b1, {N{1'b1}}};
    end
    return r;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  logic dig_err;
  logic err_q;

  function automatic logic bad_digit(input logic [3:0] d);
    return d > 4'(BCD_MAX_DIGIT);
  endfunction

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  bcd_mac_step u_mac (
    .acc_i   (acc),
    .digit_i (dig_sr[4*BCD_DIGITS-1 -: 4]),
    .acc_o   (acc_step)
  );

  assign sat_res = saturate(acc_step);
  assign busy    = (state == CONV);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
          accept    = 1'b1;
        end
      end
      CONV: begin
        if (cnt == CNT_W'(BCD_DIGITS - 1)) begin
          state_nxt = IDLE;
          last      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      dig_sr  <= '0;
      done    <= 1'b0;
      bin_out <= '0;
      ovf     <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      dig_err <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= last;
      // Capture stage: digits latched once, so a start while busy cannot disturb them.
      if (accept) begin
        dig_sr <= {mil, cen, dec, uni};
        acc    <= '0;
        cnt    <= '0;
`ifdef BCD_DIGIT_CHECK_EN
        dig_err <= bad_digit(mil) | bad_digit(cen) | bad_digit(dec) | bad_digit(uni);
`endif
      end else if (state == CONV) begin
        acc    <= acc_step;
        dig_sr <= {dig_sr[4*BCD_DIGITS-5:0], 4'h0};
        cnt    <= cnt + 1'b1;
      end
      // Result stage: the final step's sum goes straight to the output registers.
      if (last) begin
`ifdef BCD_DIGIT_CHECK_EN
        if (dig_err) begin
          bin_out <= '0;
          ovf     <= 1'b0;
          err_q   <= 1'b1;
        end else begin
          bin_out <= sat_res[N-1:0];
          ovf     <= sat_res[N];
          err_q   <= 1'b0;
        end
`else
        bin_out <= sat_res[N-1:0];
        ovf     <= sat_res[N];
`endif
      end
    end
  end

endmodule
